// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared constants and helpers for the registered 1-to-N
// stream demultiplexer.
//   CNT_W         width of the optional per-channel transfer counters
//   N_OUT_MAX     largest supported channel count
//   sel_in_range  true when a select value addresses an existing channel
package stream_demux_pkg;

  localparam int CNT_W     = 16;
  localparam int N_OUT_MAX = 16;

  function automatic logic sel_in_range(input int unsigned sel,
                                        input int unsigned n_out);
    return (sel < n_out);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output register with valid/ready handshake.
// A load writes the payload and marks the slot full. A drain (full & ready)
// empties the slot. A load in the same cycle as a drain keeps the slot full
// with the new payload. The payload register keeps its last value after a
// drain.
// Optional feature: macro STREAM_DEMUX_CNT_EN adds a 16-bit wrapping count of
// drain handshakes.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        write load_data into the slot at the next edge
//   load_data   payload to store
//   ready       consumer ready for this slot
//   valid       slot full
//   data        stored payload
//   cnt         drain handshake count (STREAM_DEMUX_CNT_EN only)
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt
`endif
);

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;

  // Slot register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (load) begin
      vld_p0  <= 1'b1;
      data_p0 <= load_data;
    end else if (vld_p0 && ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign valid = vld_p0;
  assign data  = data_p0;

`ifdef STREAM_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_p0;

  // Counts consumer handshakes, wrapping naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0 <= '0;
    end else if (vld_p0 && ready) begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  assign cnt = cnt_p0;
`endif

endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N_OUT valid/ready stream demultiplexer.
// Each input beat is steered by in_sel to one of N_OUT one-entry output slots.
// Beats whose select is out of range are consumed, dropped and flagged on
// err_sel for one cycle.
// Optional feature: macro STREAM_DEMUX_CNT_EN adds the cnt port carrying a
// 16-bit drain counter per channel.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_valid    input beat present
//   in_ready    input beat accepted this cycle (combinational, never uses in_valid)
//   in_data     input payload
//   in_sel      target channel for the beat
//   out_valid   per-channel slot full
//   out_ready   per-channel consumer ready
//   out_data    channel k in bits [k*DATA_W +: DATA_W]
//   err_sel     one-cycle pulse after an out-of-range beat was dropped
//   cnt         channel k count in bits [k*16 +: 16] (STREAM_DEMUX_CNT_EN only)
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int N_OUT  = 4,
  localparam int SEL_W  = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    err_sel
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [N_OUT*CNT_W-1:0]  cnt
`endif
);

  logic             sel_ok;
  logic [N_OUT-1:0] sel_hit;
  logic [N_OUT-1:0] load;
  logic             err_p0;

  assign sel_ok = sel_in_range(32'(in_sel), 32'(N_OUT));

  // One-hot decode instead of indexing out_valid[in_sel], so a select past
  // N_OUT never reads a nonexistent bit; such a select leaves in_ready at 1.
  always_comb begin
    sel_hit  = '0;
    in_ready = 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_hit[k] = 1'b1;
        in_ready   = !out_valid[k] || out_ready[k];
      end
    end
  end

  assign load = sel_hit & {N_OUT{in_valid && in_ready}};

  // Drop flag stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_p0 <= 1'b0;
    end else begin
      err_p0 <= in_valid && !sel_ok;
    end
  end

  assign err_sel = err_p0;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[k]),
      .load_data(in_data),
      .ready    (out_ready[k]),
      .valid    (out_valid[k]),
      .data     (out_data[k*DATA_W +: DATA_W])
`ifdef STREAM_DEMUX_CNT_EN
      ,
      .cnt      (cnt[k*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: self-checking bench for stream_demux.
// A 4-channel instance is driven by directed and random beats and compared
// against a queue-per-channel reference model. A 3-channel instance covers the
// out-of-range select drop path.
// Optional feature: macro STREAM_DEMUX_CNT_EN also checks the cnt port,
// including 16-bit wrap.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic        err_sel;

  logic        v3;
  logic        rdy3;
  logic [7:0]  d3;
  logic [1:0]  s3;
  logic [2:0]  ov3;
  logic [2:0]  or3;
  logic [23:0] od3;
  logic        err3;

`ifdef STREAM_DEMUX_CNT_EN
  logic [63:0] cnt;
  logic [47:0] cnt3;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: beats accepted but not yet consumed, per channel
  logic [7:0] q [4][$];
  logic [7:0] last [4];
  int         drained [4];
  int         seen [4];

  always #5 clk = ~clk;

  stream_demux #(.DATA_W(8), .N_OUT(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .err_sel  (err_sel)
`ifdef STREAM_DEMUX_CNT_EN
    ,
    .cnt      (cnt)
`endif
  );

  stream_demux #(.DATA_W(8), .N_OUT(3)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (v3),
    .in_ready (rdy3),
    .in_data  (d3),
    .in_sel   (s3),
    .out_valid(ov3),
    .out_ready(or3),
    .out_data (od3),
    .err_sel  (err3)
`ifdef STREAM_DEMUX_CNT_EN
    ,
    .cnt      (cnt3)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      last[k]    = 8'h00;
      drained[k] = 0;
      seen[k]    = 0;
    end
  endtask

  // One cycle: drive, check settled outputs against the model, advance model
  // and clock. Called between edges, returns 1 time unit after the next edge.
  task automatic step(input logic v, input logic [1:0] s, input logic [7:0] d,
                      input logic [3:0] r);
    logic        exp_rdy;
    logic [3:0]  exp_valid;
    logic [31:0] exp_data;
`ifdef STREAM_DEMUX_CNT_EN
    logic [63:0] exp_cnt;
`endif
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #2;
    exp_rdy = (q[s].size() == 0) || r[s];
    for (int k = 0; k < 4; k++) begin
      exp_valid[k]          = (q[k].size() != 0);
      exp_data[k*8 +: 8]    = (q[k].size() != 0) ? q[k][0] : last[k];
`ifdef STREAM_DEMUX_CNT_EN
      exp_cnt[k*16 +: 16]   = 16'(drained[k]);
`endif
    end
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_valid);
    chk("out_data", out_data, exp_data);
    chk("err_sel4", err_sel, 1'b0);
`ifdef STREAM_DEMUX_CNT_EN
    chk("cnt", cnt, exp_cnt);
`endif
    for (int k = 0; k < 4; k++) begin
      if (out_valid[k] && r[k]) seen[k]++;
      if (q[k].size() != 0 && r[k]) begin
        void'(q[k].pop_front());
        drained[k]++;
      end
    end
    if (v && exp_rdy) begin
      q[s].push_back(d);
      last[s] = d;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'b0000;
    v3 = 1'b0; s3 = 2'd0; d3 = 8'h00; or3 = 3'b000;
    model_reset();
    #12;
    chk("rst_valid", out_valid, 4'b0000);
    chk("rst_data", out_data, 32'h0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_err", err_sel, 1'b0);
    chk("rst_valid3", ov3, 3'b000);
    chk("rst_ready3", rdy3, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat to channel 2 with every consumer stalled
    step(1'b1, 2'd2, 8'hA1, 4'b0000);
    chk("tp_valid_ch2", out_valid, 4'b0100);
    chk("tp_data_ch2", out_data[23:16], 8'hA1);
    step(1'b0, 2'd2, 8'h00, 4'b0000);
    in_sel = 2'd2; #1;
    chk("tp_ready_sel2", in_ready, 1'b0);
    in_sel = 2'd0; #1;
    chk("tp_ready_sel0", in_ready, 1'b1);
    step(1'b0, 2'd0, 8'h00, 4'b0000);

    // Back-to-back burst to channel 1 with its consumer always ready
    for (int i = 0; i < 16; i++) step(1'b1, 2'd1, 8'(8'h10 + i), 4'b0010);
    step(1'b0, 2'd1, 8'h00, 4'b0010);
    chk("burst_ch1_beats", 64'(seen[1]), 64'd16);
`ifdef STREAM_DEMUX_CNT_EN
    chk("burst_cnt1", cnt[31:16], 16'd16);
`endif

    // Simultaneous drain and load on channel 3
    step(1'b1, 2'd3, 8'h33, 4'b0000);
    step(1'b1, 2'd3, 8'h55, 4'b1000);
    chk("swap_valid3", out_valid[3], 1'b1);
    chk("swap_data3", out_data[31:24], 8'h55);
    step(1'b0, 2'd0, 8'h00, 4'b1111);

    // Out-of-range select on the 3-channel instance
    in_valid = 1'b0; out_ready = 4'b0000;
    v3 = 1'b1; s3 = 2'd3; d3 = 8'hEE; or3 = 3'b000;
    #2;
    chk("oor_ready3", rdy3, 1'b1);
    @(posedge clk); #1;
    v3 = 1'b0;
    chk("oor_err_pulse", err3, 1'b1);
    chk("oor_valid3", ov3, 3'b000);
    @(posedge clk); #1;
    chk("oor_err_clear", err3, 1'b0);
    v3 = 1'b1; s3 = 2'd2; d3 = 8'h5A;
    #2;
    chk("inr_ready3", rdy3, 1'b1);
    @(posedge clk); #1;
    v3 = 1'b0;
    chk("inr_valid3", ov3, 3'b100);
    chk("inr_data3", od3[23:16], 8'h5A);
    chk("inr_err3", err3, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           8'($urandom), 4'($urandom));
    end

    // Asynchronous reset mid-stream with channels 0 and 2 full
    step(1'b0, 2'd0, 8'h00, 4'b1111);
    step(1'b1, 2'd0, 8'hC0, 4'b0000);
    step(1'b1, 2'd2, 8'hC2, 4'b0000);
    chk("pre_rst_valid", out_valid & 4'b0101, 4'b0101);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 4'b0000);
    chk("arst_data", out_data, 32'h0);
    chk("arst_ready", in_ready, 1'b1);
`ifdef STREAM_DEMUX_CNT_EN
    chk("arst_cnt", cnt, 64'h0);
`endif
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 2'd0, 8'h01, 4'b0000);
    step(1'b0, 2'd0, 8'h00, 4'b0001);

`ifdef STREAM_DEMUX_CNT_EN
    // 65537 drains on channel 0 after a fresh reset wrap the counter to 1
    #2; rst_n = 1'b0; #1; model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 2'd0, 8'h00, 4'b0001);
    for (int i = 0; i < 65536; i++) step(1'b1, 2'd0, 8'(i), 4'b0001);
    step(1'b0, 2'd0, 8'h00, 4'b0001);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    chk("wrap_cnt0", cnt[15:0], 16'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
